// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the RV32I data memory.
// A request is taken from execute over a valid/ready handshake. It is checked for a legal funct3
// and for natural alignment, then presented to the data memory for WAIT_CYCLES+1 cycles.
// The stage returns a registered response on a second valid/ready handshake and keeps
// saturating load, store and error counters for debug/CSR readout.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   req_*               request from execute (valid/ready, we, funct3, addr, wdata, rd tag)
//   mem_*               data memory port (write enable, funct3, address, write data, read data)
//   rsp_*               response to writeback (valid/ready, rdata, rd tag, is_load, err, badaddr)
//   ld/st/err_cnt_o     saturating statistics counters
module lsu_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [4:0]            req_rd_i,
  output logic                  mem_wr_en_o,
  output logic [2:0]            mem_funct3_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [4:0]            rsp_rd_o,
  output logic                  rsp_is_load_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] rsp_badaddr_o,
  output logic [CNT_WIDTH-1:0]  ld_cnt_o,
  output logic [CNT_WIDTH-1:0]  st_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [2:0] WaitInit = 3'(WAIT_CYCLES);

  state_e                state_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [4:0]            rd_q;
  logic [2:0]            wait_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_is_load_q;
  logic                  rsp_err_q;
  logic [ADDR_WIDTH-1:0] rsp_badaddr_q;
  logic [CNT_WIDTH-1:0]  ld_cnt_q, st_cnt_q, err_cnt_q;

  logic req_legal, req_aligned, req_ok;

  always_comb begin
    if (req_we_i) begin
      req_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010};
    end else begin
      req_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    // funct3[1:0] encodes the access size for both loads and stores.
    unique case (req_funct3_i[1:0])
      2'b01:   req_aligned = ~req_addr_i[0];
      2'b10:   req_aligned = (req_addr_i[1:0] == 2'b00);
      default: req_aligned = 1'b1;
    endcase
    req_ok = req_legal & req_aligned;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= 5'd0;
      wait_q        <= 3'd0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_is_load_q <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_badaddr_q <= '0;
      ld_cnt_q      <= '0;
      st_cnt_q      <= '0;
      err_cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && req_ready_q) begin
            we_q        <= req_we_i;
            funct3_q    <= req_funct3_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            rd_q        <= req_rd_i;
            req_ready_q <= 1'b0;
            if (req_ok) begin
              state_q <= StAccess;
              wait_q  <= WaitInit;
            end else begin
              // Faulting requests skip the memory entirely.
              state_q       <= StResp;
              rsp_valid_q   <= 1'b1;
              rsp_err_q     <= 1'b1;
              rsp_badaddr_q <= req_addr_i;
              rsp_rdata_q   <= '0;
              rsp_is_load_q <= ~req_we_i;
            end
          end
        end
        StAccess: begin
          if (wait_q == 3'd0) begin
            state_q       <= StResp;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b0;
            rsp_badaddr_q <= '0;
            rsp_is_load_q <= ~we_q;
            rsp_rdata_q   <= we_q ? '0 : mem_rd_data_i;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            if (rsp_err_q) begin
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            end else if (rsp_is_load_q) begin
              if (ld_cnt_q != '1) ld_cnt_q <= ld_cnt_q + 1'b1;
            end else begin
              if (st_cnt_q != '1) st_cnt_q <= st_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reset is gated in combinationally so a reset in the final access cycle blocks the write.
  assign mem_wr_en_o   = (state_q == StAccess) && (wait_q == 3'd0) && we_q && !reset_i;
  assign mem_funct3_o  = funct3_q;
  assign mem_addr_o    = addr_q;
  assign mem_wr_data_o = wdata_q;

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_rd_o      = rd_q;
  assign rsp_is_load_o = rsp_is_load_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_badaddr_o = rsp_badaddr_q;
  assign ld_cnt_o      = ld_cnt_q;
  assign st_cnt_o      = st_cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: two instances (WAIT_CYCLES 0 and 3), each with its own data memory.
// Expected responses come from a byte-addressed reference memory and per-request rules.
module tb_lsu_ctrl;
  localparam int W0 = 0;
  localparam int W1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_clear;
  logic        req_valid [2];
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_ready [2];

  logic        req_ready [2];
  logic        mem_wr_en [2];
  logic [2:0]  mem_funct3 [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wr_data [2];
  logic [31:0] mem_rd_data [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic [4:0]  rsp_rd [2];
  logic        rsp_is_load [2];
  logic        rsp_err [2];
  logic [31:0] rsp_badaddr [2];
  logic [15:0] ld_cnt [2];
  logic [15:0] st_cnt [2];
  logic [15:0] err_cnt [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_ld [2];
  int exp_st [2];
  int exp_err [2];
  logic [7:0]  ref_mem [2][256];
  logic [31:0] dmem [2][64];

  always @(posedge clk) cyc <= cyc + 1;

  lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(W0), .CNT_WIDTH(16)) dut0 (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd), .mem_wr_en_o(mem_wr_en[0]),
    .mem_funct3_o(mem_funct3[0]), .mem_addr_o(mem_addr[0]), .mem_wr_data_o(mem_wr_data[0]),
    .mem_rd_data_i(mem_rd_data[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_rd_o(rsp_rd[0]), .rsp_is_load_o(rsp_is_load[0]),
    .rsp_err_o(rsp_err[0]), .rsp_badaddr_o(rsp_badaddr[0]), .ld_cnt_o(ld_cnt[0]),
    .st_cnt_o(st_cnt[0]), .err_cnt_o(err_cnt[0])
  );

  lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(W1), .CNT_WIDTH(16)) dut1 (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd), .mem_wr_en_o(mem_wr_en[1]),
    .mem_funct3_o(mem_funct3[1]), .mem_addr_o(mem_addr[1]), .mem_wr_data_o(mem_wr_data[1]),
    .mem_rd_data_i(mem_rd_data[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_rd_o(rsp_rd[1]), .rsp_is_load_o(rsp_is_load[1]),
    .rsp_err_o(rsp_err[1]), .rsp_badaddr_o(rsp_badaddr[1]), .ld_cnt_o(ld_cnt[1]),
    .st_cnt_o(st_cnt[1]), .err_cnt_o(err_cnt[1])
  );

  // Data memory environment: 64 words, modulo indexed, combinational extended read.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] m, d;
    case (f3[1:0])
      2'b00:   begin m = 32'h0000_00FF << {a, 3'b000}; d = {4{wd[7:0]}}; end
      2'b01:   begin m = 32'h0000_FFFF << {a[1], 4'b0000}; d = {2{wd[15:0]}}; end
      default: begin m = 32'hFFFF_FFFF; d = wd; end
    endcase
    return (old & ~m) | (d & m);
  endfunction

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int k = 0; k < 2; k++) for (int i = 0; i < 64; i++) dmem[k][i] <= 32'd0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mem_wr_en[k]) begin
          dmem[k][mem_addr[k][7:2]] <= store_merge(dmem[k][mem_addr[k][7:2]], mem_wr_data[k],
                                                   mem_funct3[k], mem_addr[k][1:0]);
        end
      end
    end
  end

  assign mem_rd_data[0] = load_ext(dmem[0][mem_addr[0][7:2]], mem_funct3[0], mem_addr[0][1:0]);
  assign mem_rd_data[1] = load_ext(dmem[1][mem_addr[1][7:2]], mem_funct3[1], mem_addr[1][1:0]);

  // Reference model: byte memory of 256 bytes (address modulo 256), little-endian.
  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input int k, input logic [2:0] f3,
                                           input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = size_of(f3);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[k][8'(addr[7:0] + 8'(i))]) << (8 * i));
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input int k, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    for (int i = 0; i < size_of(f3); i++) ref_mem[k][8'(addr[7:0] + 8'(i))] = wdata[8 * i +: 8];
  endtask

  // One complete request/response on instance k; rsp_ready held low for 'hold' cycles of
  // rsp_valid before the handshake.
  task automatic do_txn(input int k, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int hold);
    logic legal, ok;
    logic [31:0] exp_rdata, exp_bad;
    int cycles, pulses, exp_lat, exp_p;
    legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    ok = legal && !((f3[1:0] == 2'b01 && addr[0]) || (f3 == 3'b010 && addr[1:0] != 2'b00));
    exp_rdata = (ok && !we) ? ref_load(k, f3, addr) : 32'd0;
    exp_bad = ok ? 32'd0 : addr;
    exp_lat = ok ? ((k == 1 ? W1 : W0) + 2) : 1;
    exp_p = (ok && we) ? 1 : 0;

    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid[k] = 1'b1;
    rsp_ready[k] = (hold == 0);
    checks++;
    if (req_ready[k] !== 1'b1) begin
      failures++; $display("FAIL txn_req_ready k=%0d got=%b exp=1", k, req_ready[k]);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;

    cycles = 0;
    pulses = 0;
    while (!rsp_valid[k] && cycles < 40) begin
      checks++;
      if (req_ready[k] !== 1'b0) begin
        failures++; $display("FAIL access_req_ready k=%0d got=%b exp=0", k, req_ready[k]);
      end
      checks++;
      if (mem_addr[k] !== addr || mem_funct3[k] !== f3 || mem_wr_data[k] !== wdata) begin
        failures++;
        $display("FAIL access_mem_fields k=%0d got=%h/%b/%h exp=%h/%b/%h", k, mem_addr[k],
                 mem_funct3[k], mem_wr_data[k], addr, f3, wdata);
      end
      if (mem_wr_en[k] === 1'b1) pulses++;
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (cycles + 1 != exp_lat) begin
      failures++; $display("FAIL rsp_latency k=%0d got=%0d exp=%0d", k, cycles + 1, exp_lat);
    end
    checks++;
    if (pulses != exp_p) begin
      failures++; $display("FAIL wr_en_pulses k=%0d got=%0d exp=%0d", k, pulses, exp_p);
    end

    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (rsp_valid[k] !== 1'b1) begin
        failures++; $display("FAIL rsp_valid k=%0d h=%0d got=%b exp=1", k, h, rsp_valid[k]);
      end
      checks++;
      if (rsp_rdata[k] !== exp_rdata) begin
        failures++; $display("FAIL rsp_rdata k=%0d got=%h exp=%h", k, rsp_rdata[k], exp_rdata);
      end
      checks++;
      if (rsp_rd[k] !== rd || rsp_is_load[k] !== !we) begin
        failures++;
        $display("FAIL rsp_rd_is_load k=%0d got=%0d/%b exp=%0d/%b", k, rsp_rd[k],
                 rsp_is_load[k], rd, !we);
      end
      checks++;
      if (rsp_err[k] !== !ok || rsp_badaddr[k] !== exp_bad) begin
        failures++;
        $display("FAIL rsp_err k=%0d got=%b/%h exp=%b/%h", k, rsp_err[k], rsp_badaddr[k],
                 !ok, exp_bad);
      end
      checks++;
      if (mem_wr_en[k] !== 1'b0 || req_ready[k] !== 1'b0) begin
        failures++;
        $display("FAIL resp_idle_outputs k=%0d got=%b/%b exp=0/0", k, mem_wr_en[k],
                 req_ready[k]);
      end
      if (h == hold) rsp_ready[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end

    if (ok && we) ref_store(k, f3, addr, wdata);
    if (!ok) exp_err[k]++;
    else if (we) exp_st[k]++;
    else exp_ld[k]++;

    checks++;
    if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
      failures++;
      $display("FAIL after_handshake k=%0d got=%b/%b exp=0/1", k, rsp_valid[k], req_ready[k]);
    end
    checks++;
    if (ld_cnt[k] !== 16'(exp_ld[k]) || st_cnt[k] !== 16'(exp_st[k]) ||
        err_cnt[k] !== 16'(exp_err[k])) begin
      failures++;
      $display("FAIL counters k=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", k, ld_cnt[k], st_cnt[k],
               err_cnt[k], exp_ld[k], exp_st[k], exp_err[k]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clear = 1'b1;
    req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; rsp_ready[k] = 1'b0;
      exp_ld[k] = 0; exp_st[k] = 0; exp_err[k] = 0;
      for (int i = 0; i < 256; i++) ref_mem[k][i] = 8'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || mem_wr_en[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_ctrl k=%0d got=%b/%b/%b exp=1/0/0", k, req_ready[k],
                 rsp_valid[k], mem_wr_en[k]);
      end
      checks++;
      if (mem_addr[k] !== 32'd0 || mem_wr_data[k] !== 32'd0 || mem_funct3[k] !== 3'd0 ||
          rsp_rdata[k] !== 32'd0 || rsp_badaddr[k] !== 32'd0 || rsp_err[k] !== 1'b0 ||
          rsp_rd[k] !== 5'd0 || rsp_is_load[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_data k=%0d got addr=%h wd=%h rdata=%h bad=%h exp=all zero", k,
                 mem_addr[k], mem_wr_data[k], rsp_rdata[k], rsp_badaddr[k]);
      end
      checks++;
      if ({ld_cnt[k], st_cnt[k], err_cnt[k]} !== 48'd0) begin
        failures++;
        $display("FAIL reset_counters k=%0d got=%0d/%0d/%0d exp=0/0/0", k, ld_cnt[k],
                 st_cnt[k], err_cnt[k]);
      end
    end
    reset = 1'b0; mem_clear = 1'b0;
  endtask

  task automatic test_word_access();
    do_txn(0, 1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 5'd1, 0);
    do_txn(0, 1'b0, 3'b010, 32'h8, 32'h0, 5'd2, 0);
  endtask

  task automatic test_byte_access();
    do_txn(0, 1'b1, 3'b000, 32'h9, 32'h80, 5'd4, 0);
    do_txn(0, 1'b0, 3'b000, 32'h9, 32'h0, 5'd5, 0);
    do_txn(0, 1'b0, 3'b100, 32'h9, 32'h0, 5'd6, 0);
  endtask

  task automatic test_misaligned();
    do_txn(0, 1'b0, 3'b001, 32'h3, 32'h0, 5'd7, 0);
    do_txn(0, 1'b1, 3'b010, 32'h6, 32'h5555_AAAA, 5'd8, 0);
  endtask

  task automatic test_illegal();
    do_txn(0, 1'b0, 3'b011, 32'h8, 32'h0, 5'd9, 0);
    do_txn(0, 1'b1, 3'b100, 32'h8, 32'h1234_5678, 5'd10, 0);
    do_txn(0, 1'b1, 3'b101, 32'h8, 32'h1234_5678, 5'd11, 0);
    // A later word load shows none of the illegal stores reached memory.
    do_txn(0, 1'b0, 3'b010, 32'h8, 32'h0, 5'd12, 0);
  endtask

  task automatic test_wait_stall();
    do_txn(1, 1'b1, 3'b010, 32'h40, 32'hA5A5_5A5A, 5'd13, 5);
    do_txn(1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd14, 5);
    do_txn(1, 1'b0, 3'b101, 32'h42, 32'h0, 5'd15, 2);
    do_txn(1, 1'b0, 3'b001, 32'h41, 32'h0, 5'd16, 3);
  endtask

  task automatic test_random();
    for (int t = 0; t < 48; t++) begin
      int k;
      logic we;
      logic [2:0] f3;
      logic [31:0] addr;
      k = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 63));
      // High address bits exercise the memory's modulo indexing.
      if ($urandom_range(0, 1) == 1) addr = addr | ($urandom & 32'hFFFF_FF00);
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        else if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      do_txn(k, we, f3, addr, $urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int n;
    logic [31:0] a [3];
    a[0] = 32'h20; a[1] = 32'h24; a[2] = 32'h28;
    n = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    @(negedge clk);
    rsp_ready[0] = 1'b1;
    req_we = 1'b1; req_funct3 = 3'b010; req_rd = 5'd20; req_addr = a[0];
    req_wdata = 32'h1111_0000;
    req_valid[0] = 1'b1;
    for (int g = 0; g < 60 && n < 3; g++) begin
      if (req_ready[0] === 1'b1) begin
        acc[n] = cyc;
        ref_store(0, 3'b010, a[n], req_wdata);
        exp_st[0]++;
        n++;
        @(posedge clk);
        #1;
        if (n < 3) begin
          req_addr = a[n];
          req_wdata = 32'h1111_0000 + 32'(n);
        end else begin
          req_valid[0] = 1'b0;
        end
      end else begin
        @(posedge clk);
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    checks++;
    if (n != 3) begin
      failures++; $display("FAIL b2b_accepts got=%0d exp=3", n);
    end
    checks++;
    if (acc[1] - acc[0] != W0 + 3 || acc[2] - acc[1] != W0 + 3) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d,%0d exp=%0d", acc[1] - acc[0], acc[2] - acc[1], W0 + 3);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (st_cnt[0] !== 16'(exp_st[0]) || rsp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got=%0d/%b exp=%0d/0", st_cnt[0], rsp_valid[0], exp_st[0]);
    end
    do_txn(0, 1'b0, 3'b010, 32'h24, 32'h0, 5'd21, 0);
  endtask

  task automatic test_reset_mid();
    do_txn(1, 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 5'd22, 0);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h1234;
    req_rd = 5'd23;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (W1) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (mem_wr_en[1] !== 1'b1) begin
      failures++; $display("FAIL final_cycle_wr_en got=%b exp=1", mem_wr_en[1]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_wr_en[1] !== 1'b0) begin
      failures++; $display("FAIL reset_suppress_wr_en got=%b exp=0", mem_wr_en[1]);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_ld[k] = 0; exp_st[k] = 0; exp_err[k] = 0;
      checks++;
      if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 ||
          {ld_cnt[k], st_cnt[k], err_cnt[k]} !== 48'd0) begin
        failures++;
        $display("FAIL reset_mid_state k=%0d got=%b/%b/%0d/%0d/%0d exp=1/0/0/0/0", k,
                 req_ready[k], rsp_valid[k], ld_cnt[k], st_cnt[k], err_cnt[k]);
      end
    end
    do_txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd24, 1);
    do_txn(0, 1'b0, 3'b010, 32'h24, 32'h0, 5'd25, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_access();
    test_byte_access();
    test_misaligned();
    test_illegal();
    test_wait_stall();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
